dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and sequencer for the single-port 256×8 data memory of the 8-bit RISC-V-style pipelined core. Two requesters share it: the pipeline MEM stage (P) and the program/data loader/debug port (L). The block grants at most one access per cycle and routes synchronous-read data back to its owner one cycle later. It bounds loader starvation with a wait counter, supports locked loader bursts, and emits a stall to the pipeline hazard logic whenever the MEM stage is denied.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced through (1..15)
- BURST_MAX, 8, maximum loader grants per locked burst (1..255)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- p_req / p_we  in  1 / 1  pipeline access request / write enable
- p_addr / p_wdata  in  ADDR_W / DATA_W  pipeline address / write data
- p_gnt  out  1  pipeline access performed this cycle
- p_rvalid / p_rdata  out  1 / DATA_W  pipeline read data valid / data
- l_req / l_we / l_lock  in  1 / 1 / 1  loader request / write enable / burst lock
- l_addr / l_wdata  in  ADDR_W / DATA_W  loader address / write data
- l_gnt  out  1  loader access performed this cycle
- l_rvalid / l_rdata  out  1 / DATA_W  loader read data valid / data
- mem_en / mem_we  out  1 / 1  memory enable / write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with mem_en=1
- stall  out  1  p_req & ~p_gnt

## Operation
- State machine states: ARB (reset state), LOCK_L, P_TURN.
- ARB: P wins if p_req and wait_cnt < MAX_WAIT. Otherwise L wins if l_req.
- ARB to LOCK_L: on an L grant with l_lock=1; burst_cnt is loaded with 1.
- LOCK_L: L has absolute priority, and P is denied even if L is idle that cycle.
  - Each L grant increments burst_cnt.
  - Exit to ARB when l_req=0 or l_lock=0, sampled at clock edge.
  - Exit to P_TURN when the grant that makes burst_cnt == BURST_MAX completes.
- P_TURN: lasts exactly one cycle; P has absolute priority (wait_cnt ignored). Then ARB.
- wait_cnt (4-bit):
  - Increments, saturating at MAX_WAIT, each cycle l_req=1 and l_gnt=0.
  - Clears on any L grant.
  - Holds when l_req=0.
- Memory mux: mem_en = p_gnt | l_gnt. mem_we/addr/wdata come from the granted requester; they are all 0 when there is no grant.
- Read return:
  - Registered tag rd_src ∈ {none, P, L} is set on a granted read (we=0).
  - Next cycle the owner's rvalid=1 and its rdata = mem_rdata.
  - The non-owner's rdata = 0, and rdata = 0 whenever rvalid=0.
- Writes never produce rvalid.
- p_gnt and l_gnt are never both 1.

## Timing
- Grants are combinational from the current req and the registered state. The access occurs in the grant cycle; read latency is 1 cycle (rvalid in cycle N+1).
- Back-to-back reads by alternating owners return correctly ordered: each cycle's rvalid belongs to the previous cycle's grant.
- Reset values, and the values held while reset is asserted:
  - state=ARB, wait_cnt=0, burst_cnt=0, rd_src=none
  - p_gnt=l_gnt=0, rvalids=0, rdatas=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, stall=0
- Reset mid-burst or with a read in flight: the pending rvalid is dropped, and after reset the block is in ARB with no memory access.
- Simultaneous requests in ARB with wait_cnt < MAX_WAIT: P wins, L waits.
- Requester dropping req while not granted: no side effect beyond wait_cnt hold.

## Test plan
- Reset, then P reads addr 0x02 (mem holds 0x03): p_gnt same cycle, next cycle p_rvalid=1, p_rdata=0x03. Stall=0 throughout.
- P and L request continuously, MAX_WAIT=4:
  - Cycles 0-3 grant P; cycle 4 grants L and stall=1.
  - Cycle 5 grants P again; wait_cnt returns 0 after the L grant.
- L locked burst writing 0x10..0x1F to addrs 0x00..0x0F with BURST_MAX=8 and P requesting:
  - 8 consecutive l_gnt, stall=1 throughout.
  - Then exactly one P grant (P_TURN); the burst resumes afterwards.
  - Memory contents are verified.
- Alternating reads, P at 0x01 (0x01) then L at 0x02 (0x03): p_rvalid with 0x01 one cycle after the first grant, then l_rvalid with 0x03. The non-owner rdata stays 0.
- Assert reset while in LOCK_L with an L read pending:
  - l_rvalid never pulses.
  - All outputs are 0 during reset.
  - The first post-reset P request is granted immediately.
- P write 0xAA to 0x05 then read 0x05: no rvalid on the write; the read returns 0xAA.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbiter and read-return sequencer for the shared single-port data memory.
// Pipeline MEM stage (P) and loader/debug port (L) share one access per cycle.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_L = 2'd1,
        P_TURN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_P    = 2'd1,
        SRC_L    = 2'd2
    } src_t;

    localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_nxt;
    logic [7:0]  r_burst_cnt;
    logic [7:0]  w_burst_nxt;
    logic [7:0]  w_burst_inc;
    src_t        r_rd_src;
    src_t        w_rd_src_nxt;
    logic        w_p_win;
    logic        w_l_win;
    logic        w_p_gnt;
    logic        w_l_gnt;

    assign w_burst_inc = r_burst_cnt + 8'd1;

    // Arbitration decision and next-state selection
    always_comb begin
        w_p_win     = 1'b0;
        w_l_win     = 1'b0;
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            ARB: begin
                if (p_req && (r_wait_cnt < WAIT_LIM)) begin
                    w_p_win = 1'b1;
                end else if (l_req) begin
                    w_l_win = 1'b1;
                    if (l_lock) begin
                        w_burst_nxt = 8'd1;
                        if (BURST_LIM == 8'd1) begin
                            w_state_nxt = P_TURN;
                            w_burst_nxt = 8'd0;
                        end else begin
                            w_state_nxt = LOCK_L;
                        end
                    end else begin
                        w_state_nxt = ARB;
                    end
                end else begin
                    w_state_nxt = ARB;
                end
            end
            LOCK_L: begin
                // P is held off for the whole burst, even on idle loader cycles
                if (l_req) begin
                    w_l_win = 1'b1;
                    if (w_burst_inc == BURST_LIM) begin
                        w_state_nxt = P_TURN;
                        w_burst_nxt = 8'd0;
                    end else if (!l_lock) begin
                        w_state_nxt = ARB;
                        w_burst_nxt = 8'd0;
                    end else begin
                        w_burst_nxt = w_burst_inc;
                    end
                end else begin
                    w_state_nxt = ARB;
                    w_burst_nxt = 8'd0;
                end
            end
            P_TURN: begin
                w_state_nxt = ARB;
                if (p_req) begin
                    w_p_win = 1'b1;
                end else if (l_req) begin
                    w_l_win = 1'b1;
                end else begin
                    w_p_win = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_burst_nxt = 8'd0;
            end
        endcase
    end

    // Loader starvation counter and read-owner tag updates
    always_comb begin
        w_wait_nxt   = r_wait_cnt;
        w_rd_src_nxt = SRC_NONE;
        if (w_l_win) begin
            w_wait_nxt = 4'd0;
        end else if (l_req && (r_wait_cnt < WAIT_LIM)) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end else begin
            w_wait_nxt = r_wait_cnt;
        end
        if (w_p_win && !p_we) begin
            w_rd_src_nxt = SRC_P;
        end else if (w_l_win && !l_we) begin
            w_rd_src_nxt = SRC_L;
        end else begin
            w_rd_src_nxt = SRC_NONE;
        end
    end

    // State, counters and read-owner tag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ARB;
            r_wait_cnt  <= 4'd0;
            r_burst_cnt <= 8'd0;
            r_rd_src    <= SRC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rd_src    <= w_rd_src_nxt;
        end
    end

    // Grants are combinational, so they are masked while reset is held
    assign w_p_gnt = w_p_win & ~reset;
    assign w_l_gnt = w_l_win & ~reset;

    // Memory port mux, grant/stall outputs and read-data steering
    always_comb begin
        p_gnt     = w_p_gnt;
        l_gnt     = w_l_gnt;
        stall     = p_req & ~w_p_gnt & ~reset;
        mem_en    = w_p_gnt | w_l_gnt;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        p_rvalid  = (r_rd_src == SRC_P);
        l_rvalid  = (r_rd_src == SRC_L);
        p_rdata   = {DATA_W{1'b0}};
        l_rdata   = {DATA_W{1'b0}};
        if (w_p_gnt) begin
            mem_we    = p_we;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
        end else if (w_l_gnt) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end else begin
            mem_we    = 1'b0;
        end
        if (p_rvalid) begin
            p_rdata = mem_rdata;
        end else if (l_rvalid) begin
            l_rdata = mem_rdata;
        end else begin
            p_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed per-cycle vectors push expected
// read returns; an independent monitor pops them when an rvalid appears.
module tb_dmem_arbiter;

    logic       clock;
    logic       reset;
    logic       p_req, p_we, l_req, l_we, l_lock;
    logic [7:0] p_addr, p_wdata, l_addr, l_wdata;
    logic       p_gnt, p_rvalid, l_gnt, l_rvalid;
    logic [7:0] p_rdata, l_rdata;
    logic       mem_en, mem_we, stall;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        int         cyc;
        logic       own_l;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_fail;
    int   cyc;
    logic [7:0] mem [256];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4), .BURST_MAX(8)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    // Synchronous-read memory; contents start as i*i-i+1 (0x01->0x01, 0x02->0x03, 0x30->0xD1)
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * i - i + 1);
        mem_rdata = 8'h00;
        forever begin
            @(posedge clock);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata     <= mem[mem_addr];
            end
        end
    end

    // Return monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (p_rvalid || l_rvalid) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid cyc=%0d got p_rvalid=%b l_rvalid=%b, required none", cyc, p_rvalid, l_rvalid);
                end else begin
                    e = q.pop_front();
                    if ({p_rvalid, l_rvalid, p_rdata, l_rdata} !== {~e.own_l, e.own_l, (e.own_l ? 8'h00 : e.data), (e.own_l ? e.data : 8'h00)}
                        || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL read_return cyc=%0d got pv=%b lv=%b pd=%h ld=%h, required cyc=%0d owner_l=%b data=%h",
                                 cyc, p_rvalid, l_rvalid, p_rdata, l_rdata, e.cyc, e.own_l, e.data);
                    end
                end
            end else begin
                n_chk++;
                if (p_rdata !== 8'h00 || l_rdata !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rdata_idle cyc=%0d got pd=%h ld=%h, required 00 00", cyc, p_rdata, l_rdata);
                end
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    n_fail++;
                    $display("FAIL missing_rvalid cyc=%0d got none, required owner_l=%b data=%h", cyc, e.own_l, e.data);
                end
            end
        end
    end

    task automatic step(input logic preq, pwe, input logic [7:0] paddr, pwd,
                        input logic lreq, lwe, llock, input logic [7:0] laddr, lwd,
                        input logic epg, elg, est, ret, input logic [7:0] erd);
        logic [17:0] exp_bus;
        @(posedge clock);
        #1;
        p_req = preq; p_we = pwe; p_addr = paddr; p_wdata = pwd;
        l_req = lreq; l_we = lwe; l_lock = llock; l_addr = laddr; l_wdata = lwd;
        if (ret) q.push_back('{cyc + 1, elg, erd});
        exp_bus = epg ? {1'b1, pwe, paddr, pwd} : (elg ? {1'b1, lwe, laddr, lwd} : 18'd0);
        @(negedge clock);
        n_chk++;
        if ({p_gnt, l_gnt, stall} !== {epg, elg, est}) begin
            n_fail++;
            $display("FAIL grant cyc=%0d got pg=%b lg=%b stall=%b, required %b %b %b", cyc, p_gnt, l_gnt, stall, epg, elg, est);
        end
        n_chk++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== exp_bus) begin
            n_fail++;
            $display("FAIL mem_bus cyc=%0d got %h, required %h", cyc, {mem_en, mem_we, mem_addr, mem_wdata}, exp_bus);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({p_gnt, l_gnt, p_rvalid, l_rvalid, p_rdata, l_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall} !== 38'd0) begin
            n_fail++;
            $display("FAIL %s got pg=%b lg=%b pv=%b lv=%b pd=%h ld=%h en=%b we=%b a=%h wd=%h st=%b, required all 0",
                     name, p_gnt, l_gnt, p_rvalid, l_rvalid, p_rdata, l_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1;
        p_req = 1'b0; p_we = 1'b0; p_addr = 8'h00; p_wdata = 8'h00;
        l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 8'h00; l_wdata = 8'h00;
        @(negedge clock);
        check_zero("reset_outputs");
        @(posedge clock); #1;
        reset = 1'b0;

        // Single P read of 0x02
        step(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
        idle();

        // Continuous contention: P x4, forced L, then P
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03);
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
        idle();

        // Alternating owners: P 0x01 then L 0x02
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03);
        idle();

        // P write 0xAA to 0x05, then read it back
        step(1'b1, 1'b1, 8'h05, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
        idle();

        // Locked loader burst against a busy pipeline
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 8'hD1);
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 1'b1, 8'(k), 8'(8'h10 + k), 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 1'b1, 8'h08, 8'h18, 1'b1, 1'b0, 1'b0, 1'b1, 8'hD1);
        for (int k = 8; k < 16; k++)
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'(k), 8'(8'h10 + k), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle();
        idle();

        // Burst contents read back
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h15);
        step(1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F);
        idle();

        // Lock with idle loader still denies P; then reset with a locked L read in flight
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hD1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check_zero("mid_burst_reset_a");
        @(negedge clock);
        check_zero("mid_burst_reset_b");
        @(posedge clock); #1;
        reset = 1'b0;
        p_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
        step(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12);
        idle();
        idle();

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
